// File: rtl/gfx_pkg.sv
// Shared definitions for the gfx renderer / framebuffer path: video timing
// defaults, the rgb332 pixel format and framebuffer addressing.
package gfx_pkg;

  localparam int unsigned DEF_H_TOTAL  = 384;
  localparam int unsigned DEF_H_VIS    = 256;
  localparam int unsigned DEF_HS_START = 280;
  localparam int unsigned DEF_HS_END   = 312;
  localparam int unsigned DEF_V_TOTAL  = 264;
  localparam int unsigned DEF_V_VIS_LO = 16;
  localparam int unsigned DEF_V_VIS_HI = 240;
  localparam int unsigned DEF_VS_START = 248;
  localparam int unsigned DEF_VS_END   = 251;

  // One bank bit plus an 8-bit row and an 8-bit column.
  localparam int unsigned FB_AW = 17;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } rgb332_t;

  typedef enum logic {
    SWAP_IDLE = 1'b0,
    SWAP_PEND = 1'b1
  } swap_state_e;

  function automatic logic [FB_AW-1:0] fb_addr(input logic bank,
                                               input logic [7:0] row,
                                               input logic [7:0] col);
    return {bank, row, col};
  endfunction

endpackage

// File: rtl/fb_scanout_if.sv
// Renderer-facing pixel write bus plus the video output bundle of the framebuffer.
interface fb_scanout_if;

  logic       ce_pix;
  logic [7:0] wr_h;
  logic [7:0] wr_v;
  logic [2:0] wr_r;
  logic [2:0] wr_g;
  logic [1:0] wr_b;
  logic       wr_done;
  logic       wr_frame;

  logic [8:0] hcount;
  logic [8:0] vcount;
  logic [2:0] red;
  logic [2:0] green;
  logic [1:0] blue;
  logic       hs;
  logic       vs;
  logic       hb;
  logic       vb;

  modport slave (
    input  ce_pix, wr_h, wr_v, wr_r, wr_g, wr_b, wr_done, wr_frame,
    output hcount, vcount, red, green, blue, hs, vs, hb, vb
  );

  modport master (
    output ce_pix, wr_h, wr_v, wr_r, wr_g, wr_b, wr_done, wr_frame,
    input  hcount, vcount, red, green, blue, hs, vs, hb, vb
  );

endinterface

// File: rtl/fb_dpram.sv
// Simple dual-port framebuffer RAM: write port A, registered read port B,
// both on clk. A read of the address being written returns the old data.
module fb_dpram
  import gfx_pkg::*;
#(
  parameter int unsigned AW = FB_AW
) (
  input  logic          clk,
  input  logic          a_we_i,
  input  logic [AW-1:0] a_addr_i,
  input  rgb332_t       a_data_i,
  input  logic [AW-1:0] b_addr_i,
  output rgb332_t       b_data_o
);

  rgb332_t mem_q [0:(1 << AW) - 1];
  rgb332_t b_data_q;

  // NOTE: state is updated with <= so every register samples pre-edge values.
  // NOTE: neither the array nor the read register is reset; a reset on RAM
  // contents prevents block-RAM mapping and the contents are rewritten anyway.
  always_ff @(posedge clk) begin
    if (a_we_i) begin
      mem_q[a_addr_i] <= a_data_i;
    end
    b_data_q <= mem_q[b_addr_i];
  end

  assign b_data_o = b_data_q;

endmodule

// File: rtl/fb_scanout.sv
// Double-buffered framebuffer: captures renderer pixels into the back bank,
// swaps banks at vertical blank, and scans the front bank out as video.
module fb_scanout
  import gfx_pkg::*;
#(
  parameter int unsigned H_TOTAL  = DEF_H_TOTAL,
  parameter int unsigned H_VIS    = DEF_H_VIS,
  parameter int unsigned HS_START = DEF_HS_START,
  parameter int unsigned HS_END   = DEF_HS_END,
  parameter int unsigned V_TOTAL  = DEF_V_TOTAL,
  parameter int unsigned V_VIS_LO = DEF_V_VIS_LO,
  parameter int unsigned V_VIS_HI = DEF_V_VIS_HI,
  parameter int unsigned VS_START = DEF_VS_START,
  parameter int unsigned VS_END   = DEF_VS_END
) (
  input logic         clk,
  input logic         reset,
  fb_scanout_if.slave bus
);

  logic [8:0]  hcount_q, hcount_d;
  logic [8:0]  vcount_q, vcount_d;
  logic        hb_int, vb_int, hs_int, vs_int;
  swap_state_e state_q, state_d;
  logic        disp_bank_q, disp_bank_d;
  logic        line_bank_q, rd_bank;
  rgb332_t     rd_data, wr_data;
  rgb332_t     rgb_q;
  logic        hs_q, vs_q, hb_q, vb_q;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    if (bus.ce_pix) begin
      if (hcount_q == 9'(H_TOTAL - 1)) begin
        hcount_d = '0;
        vcount_d = (vcount_q == 9'(V_TOTAL - 1)) ? '0 : vcount_q + 9'd1;
      end else begin
        hcount_d = hcount_q + 9'd1;
      end
    end
  end

  assign hb_int = (hcount_q >= 9'(H_VIS));
  assign vb_int = (vcount_q < 9'(V_VIS_LO)) || (vcount_q >= 9'(V_VIS_HI));
  assign hs_int = (hcount_q >= 9'(HS_START)) && (hcount_q < 9'(HS_END));
  assign vs_int = (vcount_q >= 9'(VS_START)) && (vcount_q < 9'(VS_END));

  // A frame completed outside vblank waits for the next vblank rise;
  // extra frame pulses while waiting collapse into the one pending swap.
  always_comb begin
    state_d     = state_q;
    disp_bank_d = disp_bank_q;
    case (state_q)
      SWAP_IDLE: begin
        if (bus.wr_frame) begin
          if (vb_int) begin
            disp_bank_d = ~disp_bank_q;
          end else begin
            state_d = SWAP_PEND;
          end
        end
      end
      SWAP_PEND: begin
        if (vb_int) begin
          disp_bank_d = ~disp_bank_q;
          state_d     = SWAP_IDLE;
        end
      end
      default: state_d = SWAP_IDLE;
    endcase
  end

  // The bank is latched at the start of each line so a line never mixes banks.
  assign rd_bank = (hcount_d == '0) ? disp_bank_q : line_bank_q;
  assign wr_data = '{r: bus.wr_r, g: bus.wr_g, b: bus.wr_b};

  // Read with next-state counters so the data is ready by the following ce_pix.
  fb_dpram #(.AW(FB_AW)) u_ram (
    .clk      (clk),
    .a_we_i   (bus.wr_done),
    .a_addr_i (fb_addr(~disp_bank_q, bus.wr_v, bus.wr_h)),
    .a_data_i (wr_data),
    .b_addr_i (fb_addr(rd_bank, vcount_d[7:0], hcount_d[7:0])),
    .b_data_o (rd_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hcount_q    <= '0;
      vcount_q    <= '0;
      state_q     <= SWAP_IDLE;
      disp_bank_q <= 1'b0;
      line_bank_q <= 1'b0;
      rgb_q       <= '0;
      hs_q        <= 1'b0;
      vs_q        <= 1'b0;
      hb_q        <= 1'b1;
      vb_q        <= 1'b1;
    end else begin
      hcount_q    <= hcount_d;
      vcount_q    <= vcount_d;
      state_q     <= state_d;
      disp_bank_q <= disp_bank_d;
      line_bank_q <= rd_bank;
      if (bus.ce_pix) begin
        rgb_q <= (hb_int || vb_int) ? '0 : rd_data;
        hs_q  <= hs_int;
        vs_q  <= vs_int;
        hb_q  <= hb_int;
        vb_q  <= vb_int;
      end
    end
  end

  assign bus.hcount = hcount_q;
  assign bus.vcount = vcount_q;
  assign bus.red    = rgb_q.r;
  assign bus.green  = rgb_q.g;
  assign bus.blue   = rgb_q.b;
  assign bus.hs     = hs_q;
  assign bus.vs     = vs_q;
  assign bus.hb     = hb_q;
  assign bus.vb     = vb_q;

endmodule

// File: tb/tb_fb_scanout.sv
// Directed bench for fb_scanout. The DUT runs a shrunken raster so whole frames
// stay short; every expected value below is derived from these local constants.
module tb_fb_scanout;

  localparam int HT  = 48;
  localparam int HV  = 32;
  localparam int HSS = 36;
  localparam int HSE = 40;
  localparam int VT  = 32;
  localparam int VLO = 16;
  localparam int VHI = 24;
  localparam int VSS = 26;
  localparam int VSE = 29;
  localparam int BUDGET = 20000;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   ce_div = 1;
  int   vectors = 0;
  int   miscompares = 0;

  fb_scanout_if bus ();

  fb_scanout #(
    .H_TOTAL (HT),  .H_VIS (HV),  .HS_START (HSS), .HS_END (HSE),
    .V_TOTAL (VT),  .V_VIS_LO (VLO), .V_VIS_HI (VHI),
    .VS_START (VSS), .VS_END (VSE)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial forever #5 clk = ~clk;

  // Pixel enable: one pulse every ce_div clocks, held low when ce_div is 0.
  initial begin : ce_gen
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (ce_div == 0) begin
        bus.ce_pix = 1'b0;
        cnt = 0;
      end else begin
        bus.ce_pix = (cnt == 0);
        cnt = (cnt + 1 >= ce_div) ? 0 : cnt + 1;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Waits for the counters to arrive at (h,v); waited = clocks spent.
  task automatic goto_n(input int h, input int v, output int waited);
    logic [8:0] ph, pv;
    ph = bus.hcount;
    pv = bus.vcount;
    waited = 0;
    while (waited < BUDGET) begin
      @(posedge clk);
      #1;
      waited++;
      if (bus.hcount == 9'(h) && bus.vcount == 9'(v) &&
          (bus.hcount != ph || bus.vcount != pv)) return;
      ph = bus.hcount;
      pv = bus.vcount;
    end
    vectors++;
    miscompares++;
    $display("FAIL goto_timeout: counters at (%0d,%0d), required (%0d,%0d) within %0d clks",
             bus.hcount, bus.vcount, h, v, BUDGET);
  endtask

  task automatic goto(input int h, input int v);
    int unused_n;
    goto_n(h, v, unused_n);
  endtask

  task automatic drive_write(input int h, input int v, input logic [7:0] rgb, input logic frame);
    @(negedge clk);
    bus.wr_h = 8'(h);
    bus.wr_v = 8'(v);
    {bus.wr_r, bus.wr_g, bus.wr_b} = rgb;
    bus.wr_done  = 1'b1;
    bus.wr_frame = frame;
    @(negedge clk);
    bus.wr_done  = 1'b0;
    bus.wr_frame = 1'b0;
  endtask

  task automatic drive_frame();
    @(negedge clk);
    bus.wr_frame = 1'b1;
    @(negedge clk);
    bus.wr_frame = 1'b0;
  endtask

  task automatic test_reset();
    // Power-up, run into the frame, swap once in vblank so there is state to clear.
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    goto(10, 3);
    drive_frame();
    vectors++;
    if (dut.disp_bank_q !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_reset_swap: disp_bank=%0b, want 1", dut.disp_bank_q);
    end
    ce_div = 0;
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    vectors++;
    if ({bus.hcount, bus.vcount} !== 18'd0) begin
      miscompares++;
      $display("FAIL reset_async_counters: h=%0d v=%0d, want 0 0", bus.hcount, bus.vcount);
    end
    vectors++;
    if ({bus.hs, bus.vs, bus.hb, bus.vb} !== 4'b0011) begin
      miscompares++;
      $display("FAIL reset_async_sync: hs/vs/hb/vb=%b, want 0011", {bus.hs, bus.vs, bus.hb, bus.vb});
    end
    vectors++;
    if ({bus.red, bus.green, bus.blue} !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_async_rgb: rgb=%02h, want 00", {bus.red, bus.green, bus.blue});
    end
    vectors++;
    if (dut.disp_bank_q !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_async_bank: disp_bank=%0b, want 0", dut.disp_bank_q);
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    vectors++;
    if ({bus.hcount, bus.vcount} !== 18'd0) begin
      miscompares++;
      $display("FAIL reset_release_counters: h=%0d v=%0d, want 0 0", bus.hcount, bus.vcount);
    end
    vectors++;
    if ({bus.hb, bus.vb} !== 2'b11) begin
      miscompares++;
      $display("FAIL reset_release_blank: hb/vb=%b, want 11", {bus.hb, bus.vb});
    end
    vectors++;
    if (dut.disp_bank_q !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release_bank: disp_bank=%0b, want 0", dut.disp_bank_q);
    end
  endtask

  task automatic test_timing();
    int n;
    logic [8:0] ph;
    logic exp_hs, exp_hb, exp_vs, exp_vb;
    ce_div = 4;
    goto(0, 5);
    goto_n(0, 6, n);
    vectors++;
    if (n !== HT * 4) begin
      miscompares++;
      $display("FAIL line_length: %0d clks, want %0d", n, HT * 4);
    end
    goto(HT - 1, VT - 1);
    goto_n(0, 0, n);
    vectors++;
    if (n !== 4) begin
      miscompares++;
      $display("FAIL frame_wrap: %0d clks from last pixel to (0,0), want 4", n);
    end
    goto_n(0, 0, n);
    vectors++;
    if (n !== HT * VT * 4) begin
      miscompares++;
      $display("FAIL frame_length: %0d clks, want %0d", n, HT * VT * 4);
    end
    // Horizontal sync/blank across one active line; outputs lag by one pixel.
    goto(0, 20);
    ph = bus.hcount;
    for (int i = 0; i < HT * 4; i++) begin
      @(posedge clk);
      #1;
      if (bus.hcount != ph) begin
        exp_hs = (ph >= 9'(HSS)) && (ph < 9'(HSE));
        exp_hb = (ph >= 9'(HV));
        vectors++;
        if ({bus.hs, bus.hb} !== {exp_hs, exp_hb}) begin
          miscompares++;
          $display("FAIL hsync_h%0d: hs/hb=%b, want %b", ph, {bus.hs, bus.hb}, {exp_hs, exp_hb});
        end
        if (exp_hb) begin
          vectors++;
          if ({bus.red, bus.green, bus.blue} !== 8'h00) begin
            miscompares++;
            $display("FAIL hblank_rgb_h%0d: rgb=%02h, want 00", ph, {bus.red, bus.green, bus.blue});
          end
        end
        ph = bus.hcount;
      end
    end
    // Vertical sync/blank per line, observed at the second pixel of each line.
    for (int v = 0; v < VT; v++) begin
      goto(1, v);
      exp_vs = (v >= VSS) && (v < VSE);
      exp_vb = (v < VLO) || (v >= VHI);
      vectors++;
      if ({bus.hs, bus.vs, bus.hb, bus.vb} !== {1'b0, exp_vs, 1'b0, exp_vb}) begin
        miscompares++;
        $display("FAIL vsync_v%0d: hs/vs/hb/vb=%b, want %b", v,
                 {bus.hs, bus.vs, bus.hb, bus.vb}, {1'b0, exp_vs, 1'b0, exp_vb});
      end
      if (exp_vb) begin
        vectors++;
        if ({bus.red, bus.green, bus.blue} !== 8'h00) begin
          miscompares++;
          $display("FAIL vblank_rgb_v%0d: rgb=%02h, want 00", v, {bus.red, bus.green, bus.blue});
        end
      end
    end
  endtask

  task automatic test_deferred_swap();
    ce_div = 1;
    drive_write(5, 20, 8'hE3, 1'b0);
    goto(0, 18);
    drive_frame();
    vectors++;
    if (dut.disp_bank_q !== 1'b0) begin
      miscompares++;
      $display("FAIL deferred_no_swap_active: disp_bank=%0b, want 0", dut.disp_bank_q);
    end
    goto(HT - 1, VHI - 1);
    vectors++;
    if (dut.disp_bank_q !== 1'b0) begin
      miscompares++;
      $display("FAIL deferred_no_swap_last_line: disp_bank=%0b, want 0", dut.disp_bank_q);
    end
    goto(2, VHI);
    vectors++;
    if (dut.disp_bank_q !== 1'b1) begin
      miscompares++;
      $display("FAIL deferred_swap_at_vb: disp_bank=%0b, want 1", dut.disp_bank_q);
    end
    goto(6, 20);
    vectors++;
    if ({bus.red, bus.green, bus.blue} !== 8'hE3) begin
      miscompares++;
      $display("FAIL deferred_pixel_5_20: rgb=%02h, want e3", {bus.red, bus.green, bus.blue});
    end
  endtask

  task automatic test_vblank_swap();
    drive_write(7, 20, 8'h0F, 1'b0);
    goto(0, VSS);
    drive_frame();
    vectors++;
    if (dut.disp_bank_q !== 1'b0) begin
      miscompares++;
      $display("FAIL vblank_swap_next_clk: disp_bank=%0b, want 0", dut.disp_bank_q);
    end
    @(negedge clk);
    drive_write(7, 20, 8'h5A, 1'b0);
    goto(8, 20);
    vectors++;
    if ({bus.red, bus.green, bus.blue} !== 8'h0F) begin
      miscompares++;
      $display("FAIL vblank_front_kept_7_20: rgb=%02h, want 0f", {bus.red, bus.green, bus.blue});
    end
  endtask

  task automatic test_double_frame();
    drive_frame();
    vectors++;
    if (dut.disp_bank_q !== 1'b0) begin
      miscompares++;
      $display("FAIL double_first_pend: disp_bank=%0b, want 0", dut.disp_bank_q);
    end
    goto(20, 21);
    drive_frame();
    goto(HT - 1, VHI - 1);
    vectors++;
    if (dut.disp_bank_q !== 1'b0) begin
      miscompares++;
      $display("FAIL double_no_early_swap: disp_bank=%0b, want 0", dut.disp_bank_q);
    end
    goto(2, VHI);
    vectors++;
    if (dut.disp_bank_q !== 1'b1) begin
      miscompares++;
      $display("FAIL double_one_swap: disp_bank=%0b, want 1", dut.disp_bank_q);
    end
    goto(6, 20);
    vectors++;
    if ({bus.red, bus.green, bus.blue} !== 8'hE3) begin
      miscompares++;
      $display("FAIL double_pixel_5_20: rgb=%02h, want e3", {bus.red, bus.green, bus.blue});
    end
    goto(8, 20);
    vectors++;
    if ({bus.red, bus.green, bus.blue} !== 8'h5A) begin
      miscompares++;
      $display("FAIL double_pixel_7_20: rgb=%02h, want 5a", {bus.red, bus.green, bus.blue});
    end
    goto(2, VHI);
    vectors++;
    if (dut.disp_bank_q !== 1'b1) begin
      miscompares++;
      $display("FAIL double_no_second_swap: disp_bank=%0b, want 1", dut.disp_bank_q);
    end
  endtask

  task automatic test_same_clk();
    goto(0, VSS);
    drive_write(0, VLO, 8'h1C, 1'b1);
    vectors++;
    if (dut.disp_bank_q !== 1'b0) begin
      miscompares++;
      $display("FAIL same_clk_swap: disp_bank=%0b, want 0", dut.disp_bank_q);
    end
    goto(1, VLO);
    vectors++;
    if ({bus.red, bus.green, bus.blue} !== 8'h1C) begin
      miscompares++;
      $display("FAIL same_clk_pixel_0_16: rgb=%02h, want 1c", {bus.red, bus.green, bus.blue});
    end
  endtask

  task automatic test_back_to_back();
    ce_div = 4;
    @(negedge clk);
    bus.wr_v = 8'd20;
    bus.wr_h = 8'd10;
    {bus.wr_r, bus.wr_g, bus.wr_b} = 8'h25;
    bus.wr_done = 1'b1;
    @(negedge clk);
    bus.wr_h = 8'd11;
    {bus.wr_r, bus.wr_g, bus.wr_b} = 8'h92;
    @(negedge clk);
    bus.wr_h = 8'd12;
    {bus.wr_r, bus.wr_g, bus.wr_b} = 8'h49;
    @(negedge clk);
    bus.wr_done = 1'b0;
    ce_div = 1;
    goto(0, VSS);
    drive_frame();
    vectors++;
    if (dut.disp_bank_q !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_swap: disp_bank=%0b, want 1", dut.disp_bank_q);
    end
    goto(11, 20);
    vectors++;
    if ({bus.red, bus.green, bus.blue} !== 8'h25) begin
      miscompares++;
      $display("FAIL b2b_pixel_10_20: rgb=%02h, want 25", {bus.red, bus.green, bus.blue});
    end
    @(posedge clk);
    #1;
    vectors++;
    if ({bus.red, bus.green, bus.blue} !== 8'h92) begin
      miscompares++;
      $display("FAIL b2b_pixel_11_20: rgb=%02h, want 92", {bus.red, bus.green, bus.blue});
    end
    @(posedge clk);
    #1;
    vectors++;
    if ({bus.red, bus.green, bus.blue} !== 8'h49) begin
      miscompares++;
      $display("FAIL b2b_pixel_12_20: rgb=%02h, want 49", {bus.red, bus.green, bus.blue});
    end
  endtask

  initial begin
    bus.wr_h     = '0;
    bus.wr_v     = '0;
    bus.wr_r     = '0;
    bus.wr_g     = '0;
    bus.wr_b     = '0;
    bus.wr_done  = 1'b0;
    bus.wr_frame = 1'b0;
    test_reset();
    test_timing();
    test_deferred_swap();
    test_vblank_swap();
    test_double_frame();
    test_same_clk();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
